// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: the main FSM state
// enum, the datapath mux-select constants and the instruction-class opcodes.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic       ADR_PC        = 1'b0;
  localparam logic       ADR_ALUOUT    = 1'b1;

  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] OP_DP         = 2'b00;
  localparam logic [1:0] OP_MEM        = 2'b01;
  localparam logic [1:0] OP_BR         = 2'b10;
  localparam logic [1:0] OP_UNDEF      = 2'b11;

endpackage

// File: rtl/arm_fsm_outdec.sv
// Moore output decode for the main control FSM; reset masks every strobe and
// parks the selects at their FETCH values.
module arm_fsm_outdec
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic [1:0] i_op,
  input  logic       i_mem_ready,
  input  logic       i_reset,
  output logic       o_mem_req,
  output logic       o_ir_write,
  output logic       o_next_pc,
  output logic       o_reg_w,
  output logic       o_mem_w,
  output logic       o_branch,
  output logic       o_adr_src,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_result_src,
  output logic       o_alu_op,
  output logic       o_illegal_op
);

  always_comb begin
    o_mem_req    = 1'b0;
    o_ir_write   = 1'b0;
    o_next_pc    = 1'b0;
    o_reg_w      = 1'b0;
    o_mem_w      = 1'b0;
    o_branch     = 1'b0;
    o_adr_src    = ADR_PC;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = SRCB_REG;
    o_result_src = RES_ALUOUT;
    o_alu_op     = 1'b0;
    o_illegal_op = 1'b0;

    case (i_state)
      FETCH: begin
        o_mem_req    = 1'b1;
        o_alu_src_a  = 1'b1;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALURESULT;
        o_ir_write   = i_mem_ready;
        o_next_pc    = i_mem_ready;
      end
      DECODE: begin
        o_alu_src_a  = 1'b1;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALURESULT;
        o_illegal_op = (i_op == OP_UNDEF);
      end
      MEMADR: o_alu_src_b = SRCB_IMM;
      MEMREAD: begin
        o_mem_req = 1'b1;
        o_adr_src = ADR_ALUOUT;
      end
      MEMWB: begin
        o_result_src = RES_DATA;
        o_reg_w      = 1'b1;
      end
      MEMWRITE: begin
        o_mem_req = 1'b1;
        o_mem_w   = 1'b1;
        o_adr_src = ADR_ALUOUT;
      end
      EXECUTER: o_alu_op = 1'b1;
      EXECUTEI: begin
        o_alu_src_b = SRCB_IMM;
        o_alu_op    = 1'b1;
      end
      ALUWB: o_reg_w = 1'b1;
      BRANCH: begin
        o_alu_src_b  = SRCB_IMM;
        o_result_src = RES_ALURESULT;
        o_branch     = 1'b1;
      end
      default: ;
    endcase

    // Reset overrides the decoded state so nothing is written while held.
    if (i_reset) begin
      o_mem_req    = 1'b0;
      o_ir_write   = 1'b0;
      o_next_pc    = 1'b0;
      o_reg_w      = 1'b0;
      o_mem_w      = 1'b0;
      o_branch     = 1'b0;
      o_illegal_op = 1'b0;
      o_adr_src    = ADR_PC;
      o_alu_src_a  = 1'b1;
      o_alu_src_b  = SRCB_FOUR;
      o_result_src = RES_ALURESULT;
      o_alu_op     = 1'b0;
    end
  end

endmodule

// File: rtl/arm_main_fsm.sv
// Multicycle ARM main controller: state register and next-state logic, with
// per-state outputs delegated to arm_fsm_outdec.
module arm_main_fsm
  import arm_ctrl_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_t r_state;
  state_t w_next;
  logic   w_imm;
  logic   w_load;

  assign w_imm  = Funct[5];
  assign w_load = Funct[0];

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:    w_next = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          OP_MEM:  w_next = MEMADR;
          OP_DP:   w_next = w_imm ? EXECUTEI : EXECUTER;
          OP_BR:   w_next = BRANCH;
          default: w_next = FETCH;
        endcase
      end
      MEMADR:   w_next = w_load ? MEMREAD : MEMWRITE;
      MEMREAD:  w_next = MemReady ? MEMWB : MEMREAD;
      MEMWRITE: w_next = MemReady ? FETCH : MEMWRITE;
      EXECUTER: w_next = ALUWB;
      EXECUTEI: w_next = ALUWB;
      default:  w_next = FETCH;
    endcase
  end

  assign State = r_state;

  arm_fsm_outdec u_outdec (
    .i_state      (r_state),
    .i_op         (Op),
    .i_mem_ready  (MemReady),
    .i_reset      (Reset),
    .o_mem_req    (MemReq),
    .o_ir_write   (IRWrite),
    .o_next_pc    (NextPC),
    .o_reg_w      (RegW),
    .o_mem_w      (MemW),
    .o_branch     (Branch),
    .o_adr_src    (AdrSrc),
    .o_alu_src_a  (ALUSrcA),
    .o_alu_src_b  (ALUSrcB),
    .o_result_src (ResultSrc),
    .o_alu_op     (ALUOp),
    .o_illegal_op (IllegalOp)
  );

endmodule

// File: tb/tb_arm_main_fsm.sv
// Directed and randomized bench for arm_main_fsm against a cycle-level
// reference of the control unit's documented behaviour.
module tb_arm_main_fsm;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b0;
  logic       MemReady = 1'b0;
  logic       MemReq, IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc;
  logic       ALUOp, IllegalOp;
  logic [3:0] State;

  int errors = 0;
  int checks = 0;
  int m_st   = 0;

  always #5 Clk = ~Clk;

  arm_main_fsm dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .MemReq(MemReq), .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp),
    .IllegalOp(IllegalOp), .State(State)
  );

  // Output vector: MemReq IRWrite NextPC RegW MemW Branch AdrSrc ALUSrcA ALUSrcB ResultSrc ALUOp IllegalOp
  function automatic logic [13:0] pack(input logic mreq, irw, npc, rw, mw, br, adr, sa,
                                       input logic [1:0] sb, rs, input logic aop, ill);
    return {mreq, irw, npc, rw, mw, br, adr, sa, sb, rs, aop, ill};
  endfunction

  // Reference outputs from the per-state tables; anything not listed is zero.
  function automatic logic [13:0] ref_out(input int st, input logic rst,
                                          input logic [1:0] op, input logic mr);
    if (rst) return pack(0,0,0,0,0,0, 0,1,2'd2,2'd2,0,0);
    case (st)
      0: return pack(1,mr,mr,0,0,0, 0,1,2'd2,2'd2,0,0);
      1: return pack(0,0,0,0,0,0, 0,1,2'd2,2'd2,0,(op == 2'd3));
      2: return pack(0,0,0,0,0,0, 0,0,2'd1,2'd0,0,0);
      3: return pack(1,0,0,0,0,0, 1,0,2'd0,2'd0,0,0);
      4: return pack(0,0,0,1,0,0, 0,0,2'd0,2'd1,0,0);
      5: return pack(1,0,0,0,1,0, 1,0,2'd0,2'd0,0,0);
      6: return pack(0,0,0,0,0,0, 0,0,2'd0,2'd0,1,0);
      7: return pack(0,0,0,0,0,0, 0,0,2'd1,2'd0,1,0);
      8: return pack(0,0,0,1,0,0, 0,0,2'd0,2'd0,0,0);
      9: return pack(0,0,0,0,0,1, 0,0,2'd1,2'd2,0,0);
      default: return 14'd0;
    endcase
  endfunction

  function automatic int ref_next(input int st, input logic rst, input logic [1:0] op,
                                  input logic [5:0] fn, input logic mr);
    if (rst) return 0;
    case (st)
      0: return mr ? 1 : 0;
      1: begin
        if (op == 2'd1) return 2;
        if (op == 2'd0) return fn[5] ? 7 : 6;
        if (op == 2'd2) return 9;
        return 0;
      end
      2: return fn[0] ? 3 : 5;
      3: return mr ? 4 : 3;
      5: return mr ? 0 : 5;
      6, 7: return 8;
      default: return 0;
    endcase
  endfunction

  task automatic cycle(input logic rst, input logic [1:0] op, input logic [5:0] fn, input logic mr);
    logic [13:0] got, exp;
    logic [3:0]  exp_st;
    @(negedge Clk);
    Reset = rst; Op = op; Funct = fn; MemReady = mr;
    #1;
    got = {MemReq, IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ALUOp, IllegalOp};
    exp = ref_out(m_st, rst, op, mr);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL outputs st=%0d rst=%0b op=%0d mr=%0b: got %b expected %b", m_st, rst, op, mr, got, exp);
    end
    m_st = ref_next(m_st, rst, op, fn, mr);
    @(posedge Clk);
    #1;
    exp_st = 4'(m_st);
    checks++;
    assert (State === exp_st) else begin
      errors++;
      $error("FAIL state: got %0d expected %0d", State, exp_st);
    end
  endtask

  // Run one instruction with MemReady=1 from FETCH and measure its length in cycles.
  task automatic latency(input string tag, input logic [1:0] op, input logic [5:0] fn, input int lat);
    int n = 0;
    do begin
      cycle(1'b0, op, fn, 1'b1);
      n++;
    end while (State !== 4'd0 && n < 10);
    checks++;
    assert (n === lat) else begin
      errors++;
      $error("FAIL latency %s: got %0d cycles expected %0d", tag, n, lat);
    end
  endtask

  initial begin
    // Two reset cycles (State unknown before the first edge, outputs already masked)
    cycle(1'b1, 2'd0, 6'd0, 1'b1);
    cycle(1'b1, 2'd0, 6'd0, 1'b1);

    // ADD immediate: 0,1,7,8,0
    cycle(1'b0, 2'd0, 6'b101000, 1'b1);
    cycle(1'b0, 2'd0, 6'b101000, 1'b1);
    cycle(1'b0, 2'd0, 6'b101000, 1'b1);
    cycle(1'b0, 2'd0, 6'b101000, 1'b1);

    // LDR with three wait cycles in MEMREAD
    cycle(1'b0, 2'd1, 6'b011001, 1'b1);
    cycle(1'b0, 2'd1, 6'b011001, 1'b1);
    cycle(1'b0, 2'd1, 6'b011001, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd1, 6'b011001, 1'b0);
    cycle(1'b0, 2'd1, 6'b011001, 1'b1);
    cycle(1'b0, 2'd1, 6'b011001, 1'b0);

    // FETCH stalls while memory is not ready
    cycle(1'b0, 2'd2, 6'd0, 1'b0);
    cycle(1'b0, 2'd2, 6'd0, 1'b0);

    // Latency table with MemReady held high
    latency("ldr",    2'd1, 6'b011001, 5);
    latency("str",    2'd1, 6'b011000, 4);
    latency("dp_reg", 2'd0, 6'b001000, 4);
    latency("dp_imm", 2'd0, 6'b101000, 4);
    latency("branch", 2'd2, 6'd0,      3);
    latency("undef",  2'd3, 6'd0,      2);

    // Reset raised inside MEMWRITE while memory is stalled
    cycle(1'b0, 2'd1, 6'b011000, 1'b1);
    cycle(1'b0, 2'd1, 6'b011000, 1'b1);
    cycle(1'b0, 2'd1, 6'b011000, 1'b1);
    cycle(1'b0, 2'd1, 6'b011000, 1'b0);
    cycle(1'b1, 2'd1, 6'b011000, 1'b0);
    cycle(1'b0, 2'd0, 6'd0,      1'b1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 29) == 0), 2'($urandom_range(0, 3)),
            6'($urandom_range(0, 63)), ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arm_main_fsm.md
ARM_MAIN_FSM -- requirements
Module: arm_main_fsm

Interface
REQ-001 SHALL have port Clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port Op, input, 2 bits: instruction bits [27:26] (00 data-processing, 01 memory, 10 branch, 11 undefined).
REQ-004 SHALL have port Funct, input, 6 bits: instruction bits [25:20]; Funct[5] is I (immediate), Funct[0] is L (load) or S.
REQ-005 SHALL have port MemReady, input, 1 bit: the memory has completed the current request this cycle.
REQ-006 SHALL have port MemReq, output, 1 bit: memory access request.
REQ-007 SHALL have ports IRWrite, NextPC, RegW, MemW and Branch, each output, 1 bit: datapath write strobes.
REQ-008 SHALL have port AdrSrc, output, 1 bit: address mux select (0 = PC, 1 = ALUOut).
REQ-009 SHALL have port ALUSrcA, output, 1 bit: ALU input A select (0 = register A, 1 = PC).
REQ-010 SHALL have port ALUSrcB, output, 2 bits: ALU input B select (00 = register, 01 = ExtImm, 10 = constant 4).
REQ-011 SHALL have port ResultSrc, output, 2 bits: result mux select (00 = ALUOut, 01 = Data, 10 = ALUResult).
REQ-012 SHALL have port ALUOp, output, 1 bit: 1 = the ALU decoder uses Funct, 0 = the ALU adds.
REQ-013 SHALL have port IllegalOp, output, 1 bit: one-cycle pulse on an undefined opcode.
REQ-014 SHALL have port State, output, 4 bits: current state encoding, for debug.

Function
REQ-015 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
REQ-016 In FETCH: MemReq=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10; IRWrite=1 and NextPC=1 only in the cycle where MemReady=1.
REQ-017 FETCH SHALL stay in FETCH while MemReady=0 and go to DECODE when MemReady=1.
REQ-018 In DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, no strobes.
REQ-019 DECODE SHALL transition as follows:
- Op=01 -> MEMADR
- Op=00 with Funct[5]=0 -> EXECUTER
- Op=00 with Funct[5]=1 -> EXECUTEI
- Op=10 -> BRANCH
- Op=11 -> FETCH, with IllegalOp=1 for that DECODE cycle only
REQ-020 In MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0; next state is MEMREAD if Funct[0]=1, else MEMWRITE.
REQ-021 In MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00; hold until MemReady=1, then go to MEMWB.
REQ-022 In MEMWB: ResultSrc=01, RegW=1 for exactly one cycle; next state is FETCH.
REQ-023 In MEMWRITE: MemReq=1, MemW=1, AdrSrc=1, ResultSrc=00 for every cycle of the state; hold until MemReady=1, then go to FETCH.
REQ-024 In EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1. In EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Both SHALL go to ALUWB.
REQ-025 In ALUWB: ResultSrc=00, RegW=1; next state is FETCH.
REQ-026 In BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1; next state is FETCH.
REQ-027 Any select not listed for a state SHALL be 0; any strobe not listed SHALL be 0.
REQ-028 Unused encodings 10–15 SHALL drive all strobes to 0 and go to FETCH on the next edge.
REQ-029 With MemReady held at 1, instruction latency in cycles SHALL be: LDR 5, STR 4, data-processing 4, branch 3, undefined 2.
REQ-030 MemReady SHALL be ignored in every state other than FETCH, MEMREAD and MEMWRITE.

Reset
REQ-031 While Reset=1, the rising edge SHALL load FETCH.
REQ-032 While Reset=1, MemReq, IRWrite, NextPC, RegW, MemW, Branch and IllegalOp SHALL be forced to 0 combinationally; selects SHALL take their FETCH values.
REQ-033 Reset asserted mid-instruction (including in MEMWRITE while MemReady=0) SHALL abandon the instruction; the first post-reset edge SHALL yield State=0.

Structure
REQ-034 State enum and mux-select constants (ADR_PC, ADR_ALUOUT, SRCB_REG, SRCB_IMM, SRCB_FOUR, RES_ALUOUT, RES_DATA, RES_ALURESULT) SHALL live in shared package arm_ctrl_pkg.
REQ-035 Per-state output decoding SHALL be one combinational sub-module, arm_fsm_outdec; state register and next-state logic SHALL stay in arm_main_fsm.

Verification
REQ-036 Reset=1 for 2 cycles, then 0 with MemReady=1 -> State=0 after the first edge and all strobes 0 during reset; the first post-reset cycle has IRWrite=1, NextPC=1.
REQ-037 Op=00, Funct=6'b101000 (ADD immediate), MemReady=1 -> State sequence 0,1,7,8,0; RegW=1 only in state 8.
REQ-038 Op=01, Funct=6'b011001 (LDR), MemReady low for 3 cycles in MEMREAD -> state 3 held 4 cycles with MemReq=1; then one cycle of MEMWB with ResultSrc=01, RegW=1.
REQ-039 Op=01, Funct=6'b011000 (STR), MemReady=1 -> State sequence 0,1,2,5,0; MemW=1 for exactly one cycle, with AdrSrc=1.
REQ-040 Op=10 -> State sequence 0,1,9,0 with Branch=1 in state 9; Op=11 -> State sequence 0,1,0 with IllegalOp=1 in state 1.
REQ-041 Reset raised during MEMWRITE with MemReady=0 -> MemW=0 in the same cycle and State=0 after the next edge.
